// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsr_state_t;

    // Counter width for n digits; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract slice: a - b - bin via a + ~b + ~bin.
module sub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout,
    output logic             c_msb
);

    logic [DIGIT:0] sum;

    assign sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~bin};
    assign diff = sum[DIGIT-1:0];
    assign bout = ~sum[DIGIT];
    // The MSB sum bit is a ^ ~b ^ cin, so the carry into it falls out by xor.
    assign c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ ~b[DIGIT-1];

endmodule

// File: rtl/dsr_sub.sv
// Digit-serial subtractor: D = A - B - Bi, one DIGIT slice per cycle, LSB first.
module dsr_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("dsr_sub: WIDTH must be a multiple of DIGIT");
    end

    dsr_state_t       state, nxt;
    logic [WIDTH-1:0] a_sreg, b_sreg, d_reg, d_shift;
    logic [CW-1:0]    cnt;
    logic             borrow, bo_r, v_r;
    logic [DIGIT-1:0] diff;
    logic             bout, c_msb;
    logic             accept, last;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sreg[DIGIT-1:0]),
        .b     (b_sreg[DIGIT-1:0]),
        .bin   (borrow),
        .diff  (diff),
        .bout  (bout),
        .c_msb (c_msb)
    );

    // New digit enters at the top; after N shifts the first digit sits at the LSB.
    if (N == 1) begin : g_one
        assign d_shift = diff;
    end else begin : g_many
        assign d_shift = {diff, d_reg[WIDTH-1:DIGIT]};
    end

    assign accept = in_vld & in_rdy;
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) nxt = RUN;
            end
            RUN: begin
                if (last) nxt = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                in_rdy  = out_rdy;
                if (out_rdy) nxt = in_vld ? RUN : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sreg <= '0;
            b_sreg <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            bo_r   <= 1'b0;
            v_r    <= 1'b0;
        end else if (accept) begin
            a_sreg <= A;
            b_sreg <= B;
            borrow <= Bi;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sreg <= a_sreg >> DIGIT;
            b_sreg <= b_sreg >> DIGIT;
            d_reg  <= d_shift;
            borrow <= bout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                bo_r <= bout;
                // Overflow: carry into MSB differs from carry out (= ~borrow).
                v_r  <= c_msb ^ ~bout;
            end
        end
    end

    assign D  = d_reg;
    assign Bo = bo_r;
    assign V  = v_r;

endmodule

// File: tb/tb_dsr_sub.sv
// Randomized + directed bench for dsr_sub against a queue-based arithmetic model.
module tb_dsr_sub;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;
    localparam int NOPS  = 2000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld, in_rdy, out_vld, out_rdy;
    logic [WIDTH-1:0] A, B, D;
    logic             Bi, Bo, V;

    dsr_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .A(A), .B(B), .Bi(Bi), .out_vld(out_vld), .out_rdy(out_rdy),
        .D(D), .Bo(Bo), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        int          acc;
    } op_t;

    op_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_acc = 0;
    bit  head_seen = 0;
    bit  head_late = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction; overflow when the true signed result leaves 32-bit range.
    task automatic model(input op_t o, output logic [31:0] d, output logic bo, output logic v);
        longint ud, sr;
        ud = longint'({32'd0, o.a}) - longint'({32'd0, o.b}) - longint'(o.bi);
        bo = (ud < 0);
        d  = ud[31:0];
        sr = longint'($signed(o.a)) - longint'($signed(o.b)) - longint'(o.bi);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        ebo, ev;
        op_t         o;
        if (!rst_n) begin
            q.delete();
            head_seen = 0;
            head_late = 0;
        end else begin
            if (out_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    if (!head_seen) begin
                        chk("latency", 64'(cyc - q[0].acc), 64'(N + 1));
                        head_seen = 1;
                    end
                    model(q[0], ed, ebo, ev);
                    chk("D", 64'(D), 64'(ed));
                    chk("Bo", 64'(Bo), 64'(ebo));
                    chk("V", 64'(V), 64'(ev));
                    if (out_rdy) begin
                        void'(q.pop_front());
                        head_seen = 0;
                        head_late = 0;
                    end
                end
            end else if (q.size() != 0) begin
                chk("in_rdy_busy", 64'(in_rdy), 0);
                if (!head_late && (cyc - q[0].acc > N + 1)) begin
                    chk("result_timeout", 1, 0);
                    head_late = 1;
                end
            end else begin
                chk("in_rdy_idle", 64'(in_rdy), 1);
            end
            if (in_vld && in_rdy) begin
                o.a = A; o.b = B; o.bi = Bi; o.acc = cyc;
                q.push_back(o);
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(output int k);
        k = 0;
        while (!out_vld && k < 50) begin
            tick();
            k++;
        end
        if (!out_vld) chk("wait_out_vld_timeout", 0, 1);
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (!in_rdy && k < 50) begin
            tick();
            k++;
        end
        if (!in_rdy) chk("wait_in_rdy_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [31:0] ed, input logic ebo, input logic ev);
        int k;
        out_rdy = 0;
        wait_rdy();
        A = a; B = b; Bi = bi; in_vld = 1;
        tick();
        in_vld = 0;
        wait_vld(k);
        chk("lit_D", 64'(D), 64'(ed));
        chk("lit_Bo", 64'(Bo), 64'(ebo));
        chk("lit_V", 64'(V), 64'(ev));
        out_rdy = 1;
        tick();
        out_rdy = 0;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        logic [31:0] held_d;
        logic        held_bo, held_v;

        rst_n = 0; in_vld = 0; out_rdy = 0; A = '0; B = '0; Bi = 0;
        #12;
        chk("rst_in_rdy", 64'(in_rdy), 1);
        chk("rst_out_vld", 64'(out_vld), 0);
        chk("rst_D", 64'(D), 0);
        chk("rst_Bo", 64'(Bo), 0);
        chk("rst_V", 64'(V), 0);
        #5 rst_n = 1;
        tick();

        run_op(32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0002, 0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFE, 1, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 1);

        // Back-pressure then back-to-back acceptance in DONE.
        wait_rdy();
        A = 32'h20; B = 32'h3; Bi = 0; in_vld = 1;
        tick();
        in_vld = 0;
        wait_vld(k);
        held_d = D; held_bo = Bo; held_v = V;
        chk("bp_D", 64'(held_d), 64'h1D);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_D", 64'(D), 64'(held_d));
            chk("stall_BoV", 64'({Bo, V}), 64'({held_bo, held_v}));
            chk("stall_in_rdy", 64'(in_rdy), 0);
        end
        A = 32'h10; B = 32'h01; Bi = 0; in_vld = 1; out_rdy = 1;
        #1;
        chk("b2b_in_rdy", 64'(in_rdy), 1);
        tick();
        in_vld = 0; out_rdy = 0;
        wait_vld(k);
        chk("b2b_cycles", 64'(k), 64'(N));
        chk("b2b_D", 64'(D), 64'h0F);
        out_rdy = 1;
        tick();
        out_rdy = 0;

        // Reset while digit 2 is in flight.
        wait_rdy();
        A = 32'h55; B = 32'h1; Bi = 0; in_vld = 1;
        tick();
        in_vld = 0;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("midrst_in_rdy", 64'(in_rdy), 1);
        chk("midrst_out_vld", 64'(out_vld), 0);
        chk("midrst_D", 64'(D), 0);
        @(posedge clk);
        #3 rst_n = 1;
        tick();
        chk("post_rst_out_vld", 64'(out_vld), 0);
        run_op(32'h0000_0100, 32'h0000_0001, 0, 32'h0000_00FF, 0, 0);

        // Random traffic with random handshakes on both sides.
        k = n_acc;
        for (int c = 0; c < 40000 && (n_acc - k) < NOPS; c++) begin
            in_vld  = ($urandom % 4) != 0;
            out_rdy = ($urandom % 4) != 0;
            A  = rnd();
            B  = rnd();
            Bi = 1'($urandom % 2);
            tick();
        end
        if ((n_acc - k) < NOPS) chk("random_accept_budget", 64'(n_acc - k), 64'(NOPS));
        in_vld = 0;
        out_rdy = 1;
        for (int c = 0; c < 50 && q.size() != 0; c++) tick();
        chk("drain_empty", 64'(q.size()), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
